// File: rtl/boot_seq_ctrl_pkg.sv
// boot_seq_pkg: shared state encoding and sizing constants for the boot sequencer
package boot_seq_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_SYNC,
        ST_CHECK,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_e;
    localparam int SYNC_CYCLES = 2;
    localparam int BUF_DEPTH   = 2;
    localparam int OCC_W       = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W       = $clog2(BUF_DEPTH);
endpackage

// File: rtl/boot_seq_ctrl_if.sv
// boot_seq_ctrl_if: memory read port and output stream bundle of the boot sequencer
//   master (sequencer): drives mem_rd_en/mem_addr and s_data/s_valid, receives mem_rdata/s_ready
//   slave (memory + downstream): the mirror image
interface boot_seq_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    modport master (output mem_rd_en, mem_addr, s_data, s_valid, input mem_rdata, s_ready);
    modport slave  (input mem_rd_en, mem_addr, s_data, s_valid, output mem_rdata, s_ready);
endinterface

// File: rtl/boot_seq_ctrl_skid.sv
// boot_seq_skid: 2-entry output FIFO with flush and occupancy
//   clk, clr_n    : clock, synchronous active-low reset
//   flush         : drop all entries (wins over push/pop)
//   push/push_data: enqueue a word
//   pop           : dequeue the head word
//   head, occ     : head word and entry count
module boot_seq_skid
    import boot_seq_pkg::*;
#(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [OCC_W-1:0] occ
);
    logic [W-1:0]     mem_q [BUF_DEPTH];
    logic [W-1:0]     mem_d [BUF_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = push_data;
        wr_d  = flush ? '0 : wr_q + PTR_W'(push);
        rd_d  = flush ? '0 : rd_q + PTR_W'(pop);
        occ_d = flush ? '0 : occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    assign head = mem_q[rd_q];
    assign occ  = occ_q;
endmodule

// File: rtl/boot_seq_ctrl.sv
// boot_seq_ctrl: PMU bitstream boot sequencer (bootloader setup, range check, fetch, stream out)
//   clk, clr_n               : clock, synchronous active-low reset
//   cfg_we/cfg_addr/cfg_len  : program the bootloader with start address and length
//   start, abort             : begin / cancel a load
//   bl_*                     : bootloader register block control and readback
//   bus (master)             : memory read port and valid/ready output stream
//   chk_exp, chk_o           : expected / running checksum (BOOT_SEQ_CHKSUM_EN enables it)
//   busy, done, err          : status; err[0] range overflow, err[1] checksum mismatch
module boot_seq_ctrl
    import boot_seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_LENGTH = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   cfg_we,
    input  logic [ADDR_WIDTH-1:0]  cfg_addr,
    input  logic [DATA_LENGTH-1:0] cfg_len,
    input  logic                   start,
    input  logic                   abort,
    output logic                   bl_clr,
    output logic                   bl_rw,
    output logic [ADDR_WIDTH-1:0]  bl_addr,
    output logic [DATA_LENGTH-1:0] bl_len,
    input  logic [ADDR_WIDTH-1:0]  bl_addr_o,
    input  logic [DATA_LENGTH-1:0] bl_len_o,
    boot_seq_ctrl_if.master        bus,
    input  logic [DATA_WIDTH-1:0]  chk_exp,
    output logic [DATA_WIDTH-1:0]  chk_o,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             err
);
    localparam logic [DATA_LENGTH:0] ADDR_MAX = (DATA_LENGTH + 1)'(2 ** ADDR_WIDTH - 1);

    state_e                 state_q;
    logic [1:0]             sync_q;
    logic                   go_q;
    logic [ADDR_WIDTH-1:0]  base_q, bl_addr_q;
    logic [DATA_LENGTH-1:0] rem_q, bl_len_q, cnt_q;
    logic                   inflight_q;
    logic [1:0]             err_q;
    logic [DATA_WIDTH-1:0]  chk_q;
    logic [OCC_W-1:0]       occ;
    logic [DATA_WIDTH-1:0]  head;
    logic [DATA_LENGTH:0]   last_addr;
    logic                   abort_pulse, pop, issue, push, buf_pop, range_err, mismatch;

    assign abort_pulse = abort && state_q != ST_IDLE;
    assign pop         = bus.s_valid && bus.s_ready;
    // A read may only be issued if every word it could add still fits in the buffer.
    assign issue       = state_q == ST_FETCH && !abort && rem_q != '0 &&
                         (3'(occ) + 3'(inflight_q) < 3'd2 + 3'(pop));
    // Returning data bypasses the empty buffer; it is stored only if not taken at once.
    assign push        = inflight_q && !(occ == '0 && bus.s_ready);
    assign buf_pop     = occ != '0 && bus.s_ready;
    assign last_addr   = (DATA_LENGTH + 1)'(bl_addr_o) + (DATA_LENGTH + 1)'(bl_len_o)
                         - (DATA_LENGTH + 1)'(1);
    assign range_err   = last_addr > ADDR_MAX;

`ifdef BOOT_SEQ_CHKSUM_EN
    assign mismatch = chk_q != chk_exp;
`else
    logic unused_chk;
    assign unused_chk = ^chk_exp;
    assign mismatch   = 1'b0;
`endif

    boot_seq_skid #(.W(DATA_WIDTH)) u_skid (
        .clk      (clk),
        .clr_n    (clr_n),
        .flush    (abort_pulse),
        .push     (push),
        .push_data(bus.mem_rdata),
        .pop      (buf_pop),
        .head     (head),
        .occ      (occ)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            sync_q     <= '0;
            go_q       <= 1'b0;
            base_q     <= '0;
            bl_addr_q  <= '0;
            rem_q      <= '0;
            bl_len_q   <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            err_q      <= '0;
            chk_q      <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                cnt_q <= cnt_q + DATA_LENGTH'(1);
                rem_q <= rem_q - DATA_LENGTH'(1);
            end
`ifdef BOOT_SEQ_CHKSUM_EN
            if (pop) chk_q <= chk_q + bus.s_data;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (cfg_we) begin
                        bl_addr_q <= cfg_addr;
                        bl_len_q  <= cfg_len;
                        go_q      <= 1'b0;
                        state_q   <= ST_CFG;
                    end else if (start) begin
                        go_q    <= 1'b1;
                        err_q   <= '0;
                        chk_q   <= '0;
                        cnt_q   <= '0;
                        sync_q  <= '0;
                        state_q <= ST_SYNC;
                    end
                end
                ST_CFG: begin
                    sync_q  <= '0;
                    state_q <= ST_SYNC;
                end
                ST_SYNC: begin
                    sync_q <= sync_q + 2'd1;
                    if (sync_q == 2'(SYNC_CYCLES - 1)) state_q <= go_q ? ST_CHECK : ST_IDLE;
                end
                ST_CHECK: begin
                    base_q <= bl_addr_o;
                    rem_q  <= bl_len_o;
                    if (bl_len_o == '0) state_q <= ST_DONE;
                    else if (range_err) begin
                        err_q[0] <= 1'b1;
                        state_q  <= ST_IDLE;
                    end else state_q <= ST_FETCH;
                end
                ST_FETCH: if (issue && rem_q == DATA_LENGTH'(1)) state_q <= ST_DRAIN;
                // Leave once the word leaving this cycle is the last one held anywhere.
                ST_DRAIN: if (3'(occ) + 3'(inflight_q) == 3'(pop)) state_q <= ST_DONE;
                ST_DONE: begin
                    if (mismatch && !abort) err_q[1] <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            if (abort_pulse) begin
                state_q    <= ST_IDLE;
                inflight_q <= 1'b0;
            end
        end
    end

    assign bus.mem_rd_en = issue;
    assign bus.mem_addr  = issue ? base_q + cnt_q[ADDR_WIDTH-1:0] : '0;
    assign bus.s_valid   = occ != '0 || inflight_q;
    assign bus.s_data    = occ != '0 ? head : (inflight_q ? bus.mem_rdata : '0);
    assign bl_clr        = !clr_n || abort_pulse;
    assign bl_rw         = state_q == ST_CFG;
    assign bl_addr       = bl_addr_q;
    assign bl_len        = bl_len_q;
    assign busy          = state_q != ST_IDLE;
    assign done          = state_q == ST_DONE && !mismatch && !abort;
    assign err           = err_q;
    assign chk_o         = chk_q;
endmodule

// File: tb/tb_boot_seq_ctrl.sv
// tb_boot_seq_ctrl: directed self-checking bench for boot_seq_ctrl (honours BOOT_SEQ_CHKSUM_EN)
module tb_boot_seq_ctrl;
    logic        clk = 1'b0, clr_n = 1'b0, cfg_we = 1'b0, start = 1'b0, abort = 1'b0;
    logic [7:0]  cfg_addr = '0;
    logic [31:0] cfg_len = '0, chk_exp = '0;
    logic        bl_clr, bl_rw, busy, done;
    logic [7:0]  bl_addr, bl_addr_o;
    logic [31:0] bl_len, bl_len_o, chk_o;
    logic [1:0]  err;
    logic [7:0]  st_addr;
    logic [31:0] st_len;

    int checks = 0, errors = 0, cyc = 0, t0 = 0;
    logic [7:0]  rd_q [$];
    logic [31:0] got [$];
    int first_rd, first_sv, done_cnt, done_cyc, clr_cnt, stall_viol, max_buf, buffered;
    logic prev_rd, prev_stall;
    logic [31:0] prev_data;

    boot_seq_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    boot_seq_ctrl #(.ADDR_WIDTH(8), .DATA_LENGTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .clr_n(clr_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
        .start(start), .abort(abort), .bl_clr(bl_clr), .bl_rw(bl_rw), .bl_addr(bl_addr),
        .bl_len(bl_len), .bl_addr_o(bl_addr_o), .bl_len_o(bl_len_o), .bus(bus),
        .chk_exp(chk_exp), .chk_o(chk_o), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_word(input logic [7:0] a);
        return (a >= 8'h40 && a <= 8'h42) ? 32'(a - 8'h3F) : 32'hA500_0000 + 32'(a);
    endfunction

    function automatic logic [31:0] sum_words(input logic [7:0] a, input int n);
        logic [31:0] s = '0;
        for (int i = 0; i < n; i++) s += exp_word(a + 8'(i));
        return s;
    endfunction

    always @(posedge clk) begin
        if (bl_clr) begin
            st_addr <= '0;
            st_len  <= '0;
        end else if (bl_rw) begin
            st_addr <= bl_addr;
            st_len  <= bl_len;
        end
        if (bus.mem_rd_en) bus.mem_rdata <= exp_word(bus.mem_addr);
    end
    assign bl_addr_o = st_addr;
    assign bl_len_o  = st_len;

    always @(negedge clk) if (clr_n) begin
        buffered = rd_q.size() - got.size() - (prev_rd ? 1 : 0);
        if (buffered > max_buf) max_buf = buffered;
        if (bus.mem_rd_en) begin
            rd_q.push_back(bus.mem_addr);
            if (first_rd < 0) first_rd = cyc;
        end
        if (bus.s_valid && first_sv < 0) first_sv = cyc;
        if (prev_stall && (!bus.s_valid || bus.s_data !== prev_data)) stall_viol++;
        if (bus.s_valid && bus.s_ready) got.push_back(bus.s_data);
        prev_stall = bus.s_valid && !bus.s_ready;
        prev_data  = bus.s_data;
        prev_rd    = bus.mem_rd_en;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bl_clr) clr_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd_q.delete();
        got.delete();
        first_rd = -1; first_sv = -1; done_cnt = 0; done_cyc = -1; clr_cnt = 0;
        stall_viol = 0; max_buf = 0; prev_rd = 1'b0; prev_stall = 1'b0;
    endtask

    task automatic do_cfg(input logic [7:0] a, input logic [31:0] l);
        cfg_addr = a; cfg_len = l; cfg_we = 1'b1;
        step(1);
        cfg_we = 1'b0;
        step(3);
    endtask

    task automatic do_start();
        start = 1'b1;
        t0 = cyc;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL %s_timeout busy=%b required 0", tag, busy);
            errors++;
        end
        step(1);
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        bus.s_ready = 1'b1;
        step(2);
        checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b exp 0", busy); errors++; end
        checks++; if (bl_clr !== 1'b1) begin $display("FAIL reset_bl_clr got %b exp 1", bl_clr); errors++; end
        checks++; if ({bl_rw, bus.mem_rd_en, bus.s_valid, done} !== 4'b0) begin
            $display("FAIL reset_ctl got %b exp 0000", {bl_rw, bus.mem_rd_en, bus.s_valid, done}); errors++; end
        checks++; if ({bl_addr, bl_len, bus.mem_addr, bus.s_data, chk_o, err} !== '0) begin
            $display("FAIL reset_regs addr=%h len=%h maddr=%h sdata=%h chk=%h err=%b exp all 0",
                     bl_addr, bl_len, bus.mem_addr, bus.s_data, chk_o, err); errors++; end
        clr_n = 1'b1;
        step(1);
        checks++; if (bl_clr !== 1'b0) begin $display("FAIL reset_release_bl_clr got %b exp 0", bl_clr); errors++; end
    endtask

    task automatic test_basic();
        cfg_addr = 8'h10; cfg_len = 32'd4; cfg_we = 1'b1;
        step(1);
        cfg_we = 1'b0;
        checks++; if ({bl_rw, bl_addr, bl_len} !== {1'b1, 8'h10, 32'd4}) begin
            $display("FAIL cfg_write rw=%b addr=%h len=%0d exp 1 10 4", bl_rw, bl_addr, bl_len); errors++; end
        step(1);
        checks++; if (bl_rw !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL cfg_sync rw=%b busy=%b exp 0 1", bl_rw, busy); errors++; end
        step(2);
        checks++; if (busy !== 1'b0) begin $display("FAIL cfg_idle busy=%b exp 0", busy); errors++; end
        chk_exp = sum_words(8'h10, 4);
        clear_mon();
        do_start();
        wait_idle(40, "basic");
        checks++; if (rd_q.size() != 4) begin $display("FAIL basic_reads got %0d exp 4", rd_q.size()); errors++; end
        for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
            checks++; if (rd_q[i] !== 8'h10 + 8'(i)) begin
                $display("FAIL basic_addr%0d got %h exp %h", i, rd_q[i], 8'h10 + 8'(i)); errors++; end
        end
        checks++; if (got.size() != 4) begin $display("FAIL basic_words got %0d exp 4", got.size()); errors++; end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_word(8'h10 + 8'(i))) begin
                $display("FAIL basic_word%0d got %h exp %h", i, got[i], exp_word(8'h10 + 8'(i))); errors++; end
        end
        checks++; if (first_rd != t0 + 4) begin $display("FAIL basic_first_rd got %0d exp %0d", first_rd, t0 + 4); errors++; end
        checks++; if (first_sv != t0 + 5) begin $display("FAIL basic_first_valid got %0d exp %0d", first_sv, t0 + 5); errors++; end
        checks++; if (done_cnt != 1 || done_cyc != t0 + 9) begin
            $display("FAIL basic_done count=%0d cyc=%0d exp 1 %0d", done_cnt, done_cyc, t0 + 9); errors++; end
        checks++; if (err !== 2'b00) begin $display("FAIL basic_err got %b exp 00", err); errors++; end
    endtask

    task automatic test_range();
        do_cfg(8'hFE, 32'd4);
        clear_mon();
        do_start();
        step(2);
        checks++; if (busy !== 1'b1) begin $display("FAIL range_check_busy got %b exp 1", busy); errors++; end
        step(1);
        checks++; if (busy !== 1'b0 || err !== 2'b01) begin
            $display("FAIL range_abort busy=%b err=%b exp 0 01", busy, err); errors++; end
        step(4);
        checks++; if (rd_q.size() != 0 || done_cnt != 0) begin
            $display("FAIL range_quiet reads=%0d done=%0d exp 0 0", rd_q.size(), done_cnt); errors++; end
    endtask

    task automatic test_boundary();
        do_cfg(8'hFC, 32'd4);
        chk_exp = sum_words(8'hFC, 4);
        clear_mon();
        do_start();
        wait_idle(40, "boundary");
        checks++; if (rd_q.size() != 4 || rd_q[3] !== 8'hFF) begin
            $display("FAIL boundary_reads n=%0d last=%h exp 4 ff", rd_q.size(), rd_q.size() ? rd_q[rd_q.size()-1] : 8'h0);
            errors++; end
        checks++; if (done_cnt != 1 || err !== 2'b00) begin
            $display("FAIL boundary_done done=%0d err=%b exp 1 00", done_cnt, err); errors++; end
    endtask

    task automatic test_zero();
        do_cfg(8'h50, 32'd0);
        chk_exp = '0;
        clear_mon();
        do_start();
        wait_idle(20, "zero");
        checks++; if (done_cnt != 1 || done_cyc != t0 + 4) begin
            $display("FAIL zero_done count=%0d cyc=%0d exp 1 %0d", done_cnt, done_cyc, t0 + 4); errors++; end
        checks++; if (rd_q.size() != 0 || got.size() != 0 || err !== 2'b00) begin
            $display("FAIL zero_quiet reads=%0d words=%0d err=%b exp 0 0 00", rd_q.size(), got.size(), err); errors++; end
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_cfg(8'h20, 32'd8);
        chk_exp = sum_words(8'h20, 8);
        bus.s_ready = 1'b0;
        clear_mon();
        do_start();
        step(8);
        checks++; if (rd_q.size() != 2) begin $display("FAIL bp_stall_reads got %0d exp 2", rd_q.size()); errors++; end
        checks++; if (bus.s_valid !== 1'b1 || bus.s_data !== exp_word(8'h20)) begin
            $display("FAIL bp_stall_head valid=%b data=%h exp 1 %h", bus.s_valid, bus.s_data, exp_word(8'h20)); errors++; end
        while (busy && n < 100) begin
            bus.s_ready = ~bus.s_ready;
            step(1);
            n++;
        end
        bus.s_ready = 1'b1;
        wait_idle(10, "bp");
        checks++; if (got.size() != 8 || rd_q.size() != 8) begin
            $display("FAIL bp_counts words=%0d reads=%0d exp 8 8", got.size(), rd_q.size()); errors++; end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_word(8'h20 + 8'(i))) begin
                $display("FAIL bp_word%0d got %h exp %h", i, got[i], exp_word(8'h20 + 8'(i))); errors++; end
        end
        checks++; if (max_buf > 2) begin $display("FAIL bp_buffered got %0d exp <=2", max_buf); errors++; end
        checks++; if (stall_viol != 0) begin $display("FAIL bp_stable got %0d changes exp 0", stall_viol); errors++; end
        checks++; if (done_cnt != 1) begin $display("FAIL bp_done got %0d exp 1", done_cnt); errors++; end
    endtask

    task automatic test_abort();
        do_cfg(8'h30, 32'd8);
        bus.s_ready = 1'b1;
        clear_mon();
        do_start();
        step(6);
        abort = 1'b1;
        #1;
        checks++; if (bl_clr !== 1'b1) begin $display("FAIL abort_bl_clr got %b exp 1", bl_clr); errors++; end
        step(1);
        abort = 1'b0;
        #1;
        checks++; if ({bl_clr, bus.s_valid, busy, bus.mem_rd_en} !== 4'b0) begin
            $display("FAIL abort_after clr/valid/busy/rd got %b exp 0000",
                     {bl_clr, bus.s_valid, busy, bus.mem_rd_en}); errors++; end
        step(4);
        checks++; if (done_cnt != 0 || clr_cnt != 1 || err !== 2'b00 || got.size() != 3) begin
            $display("FAIL abort_summary done=%0d clr=%0d err=%b words=%0d exp 0 1 00 3",
                     done_cnt, clr_cnt, err, got.size()); errors++; end
        do_cfg(8'h30, 32'd3);
        chk_exp = sum_words(8'h30, 3);
        clear_mon();
        do_start();
        wait_idle(30, "reload");
        checks++; if (got.size() != 3 || done_cnt != 1 || err !== 2'b00) begin
            $display("FAIL reload_summary words=%0d done=%0d err=%b exp 3 1 00", got.size(), done_cnt, err); errors++; end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_word(8'h30 + 8'(i))) begin
                $display("FAIL reload_word%0d got %h exp %h", i, got[i], exp_word(8'h30 + 8'(i))); errors++; end
        end
    endtask

    task automatic test_chksum();
        do_cfg(8'h40, 32'd3);
        chk_exp = 32'd5;
        clear_mon();
        do_start();
        wait_idle(30, "chk_bad");
`ifdef BOOT_SEQ_CHKSUM_EN
        checks++; if (chk_o !== 32'd6 || err !== 2'b10 || done_cnt != 0) begin
            $display("FAIL chk_mismatch chk=%0d err=%b done=%0d exp 6 10 0", chk_o, err, done_cnt); errors++; end
        chk_exp = 32'd6;
        clear_mon();
        do_start();
        wait_idle(30, "chk_good");
        checks++; if (chk_o !== 32'd6 || err !== 2'b00 || done_cnt != 1) begin
            $display("FAIL chk_match chk=%0d err=%b done=%0d exp 6 00 1", chk_o, err, done_cnt); errors++; end
`else
        checks++; if (chk_o !== 32'd0 || err !== 2'b00 || done_cnt != 1) begin
            $display("FAIL chk_disabled chk=%0d err=%b done=%0d exp 0 00 1", chk_o, err, done_cnt); errors++; end
`endif
    endtask

    task automatic test_reset_midload();
        do_cfg(8'h10, 32'd6);
        clear_mon();
        do_start();
        step(5);
        clr_n = 1'b0;
        #1;
        checks++; if (bl_clr !== 1'b1) begin $display("FAIL midreset_bl_clr got %b exp 1", bl_clr); errors++; end
        step(1);
        checks++; if ({busy, bus.s_valid, bus.mem_rd_en} !== 3'b0 || bl_addr !== 8'h00) begin
            $display("FAIL midreset_state busy/valid/rd=%b bl_addr=%h exp 000 00",
                     {busy, bus.s_valid, bus.mem_rd_en}, bl_addr); errors++; end
        clr_n = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_boundary();
        test_zero();
        test_backpressure();
        test_abort();
        test_chksum();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t limit 500000", $time);
        $fatal(1);
    end
endmodule
